bus_cycle_master: RTL and testbench

- Synchronous 6502-style bus initiator on the CPU side of the 7501 adapter.
- Converts single-beat host commands (read/write, 16-bit address, 8-bit data) into phi2-framed bus cycles on address_6502/data_6502/r_w_6502.
- Honours aec: cycles are held off or retried while the video chip owns the bus.
- Used for debug/DMA injection and as the stimulus source for adapter bring-up. It drives the same side that the adapter responds to.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_cycle_master_phi2_gen.sv | 49 ++++
 rtl/bus_cycle_master.sv | 182 ++++++++++++++++++
 tb/tb_bus_cycle_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared definitions for the 6502-style bus cycle master
//
// Purpose: FSM state encoding, 6502 read/write polarity constants and the
// 7501 on-chip PIO register addresses used as convenient bench targets.
// Ports: none (package).
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_AEC = 2'd1,
    ST_CYCLE    = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // 6502 polarity: r_w high means read.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [15:0] PIO_DDR_ADDR  = 16'h0000;
  localparam logic [15:0] PIO_DATA_ADDR = 16'h0001;

endpackage

// File: rtl/bus_cycle_master_phi2_gen.sv
// rtl/bus_cycle_master_phi2_gen.sv - phase counter and phi2 generator
//
// Purpose: counts clock ticks within one bus cycle while run_i is high and
// derives phi2 (low for the first half, high for the second half).
// Ports:
//   clock        system clock
//   _reset       asynchronous active-low reset
//   run_i        high while the master is in a bus cycle; counter held at 0 otherwise
//   phi2_o       bus phase clock
//   last_tick_o  high on the final tick of the cycle (counter about to wrap)
//   phi2_rise_o  high on the tick just before phi2 goes high
module phi2_gen #(
  parameter int CYCLE_CLKS = 8
) (
  input  logic clock,
  input  logic _reset,
  input  logic run_i,
  output logic phi2_o,
  output logic last_tick_o,
  output logic phi2_rise_o
);

  localparam int CNT_W = (CYCLE_CLKS < 2) ? 1 : $clog2(CYCLE_CLKS);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CYCLE_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(CYCLE_CLKS / 2);
  localparam logic [CNT_W-1:0] PRE_RISE = CNT_W'(CYCLE_CLKS / 2 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phi2_o      = run_i && (cnt_q >= HALF);
  assign last_tick_o = run_i && (cnt_q == LAST);
  assign phi2_rise_o = run_i && (cnt_q == PRE_RISE);

endmodule

// File: rtl/bus_cycle_master.sv
// rtl/bus_cycle_master.sv - single-beat host command to 6502 bus cycle initiator
//
// Purpose: accepts one read/write command at a time, waits for aec, runs a
// phi2-framed bus cycle, retries when the video chip steals the bus during
// phi2-high, and reports completion with a one-clock response pulse.
// Ports:
//   clock, _reset              system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only when idle)
//   cmd_rw/cmd_addr/cmd_wdata  command fields, latched on accept
//   rsp_valid/rsp_rdata/rsp_err  completion pulse, read data, retries-exhausted flag
//   phi2, r_w_6502, address_6502, data_6502  6502-side bus
//   aec                        1 = CPU side owns the bus
//   busy                       high whenever not idle
module bus_cycle_master
  import bus_pkg::*;
#(
  parameter int CYCLE_CLKS = 8,
  parameter int RETRY_MAX  = 15
) (
  input  logic        clock,
  input  logic        _reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        phi2,
  output logic        r_w_6502,
  output logic [15:0] address_6502,
  inout  wire  [7:0]  data_6502,
  input  logic        aec,
  output logic        busy
);

  localparam int RT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  state_e      state_q, state_d;
  logic        cmd_rw_q, cmd_rw_d;
  logic [15:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]  cmd_wdata_q, cmd_wdata_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [RT_W-1:0] retry_q, retry_d;
  logic        err_q, err_d;
  logic        lost_q, lost_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  rdata_q, rdata_d;

  logic last_tick;
  logic phi2_rise;
  logic lost_now;
  logic data_oe;

  phi2_gen #(
    .CYCLE_CLKS(CYCLE_CLKS)
  ) u_phi2_gen (
    .clock       (clock),
    ._reset      (_reset),
    .run_i       (state_q == ST_CYCLE),
    .phi2_o      (phi2),
    .last_tick_o (last_tick),
    .phi2_rise_o (phi2_rise)
  );

  always_comb begin
    state_d     = state_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    retry_d     = retry_q;
    err_d       = err_q;
    lost_d      = lost_q;
    hold_d      = hold_q;
    rdata_d     = rdata_q;
    // The final phi2-high sample is taken on the same edge as the decision.
    lost_now    = lost_q | (phi2 & ~aec);

    case (state_q)
      ST_IDLE: begin
        rw_d = RW_READ;
        if (cmd_valid) begin
          cmd_rw_d    = cmd_rw;
          cmd_addr_d  = cmd_addr;
          cmd_wdata_d = cmd_wdata;
          state_d     = ST_WAIT_AEC;
        end
      end

      ST_WAIT_AEC: begin
        if (aec) begin
          rw_d    = cmd_rw_q;
          addr_d  = cmd_addr_q;
          state_d = ST_CYCLE;
        end
      end

      ST_CYCLE: begin
        // Clear just before phi2-high so each attempt is judged on its own.
        if (phi2_rise) begin
          lost_d = 1'b0;
        end else if (phi2 && !aec) begin
          lost_d = 1'b1;
        end
        if (last_tick) begin
          hold_d = data_6502;
          if (!lost_now) begin
            state_d = ST_DONE;
          end else if (retry_q < RT_W'(RETRY_MAX)) begin
            retry_d = retry_q + 1'b1;
            rw_d    = RW_READ;
            state_d = ST_WAIT_AEC;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (!err_q && (cmd_rw_q == RW_READ)) begin
          rdata_d = hold_q;
        end
        rw_d    = RW_READ;
        retry_d = '0;
        err_d   = 1'b0;
        lost_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q     <= ST_IDLE;
      cmd_rw_q    <= RW_READ;
      cmd_addr_q  <= 16'h0000;
      cmd_wdata_q <= 8'h00;
      rw_q        <= RW_READ;
      addr_q      <= 16'h0000;
      retry_q     <= '0;
      err_q       <= 1'b0;
      lost_q      <= 1'b0;
      hold_q      <= 8'h00;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      retry_q     <= retry_d;
      err_q       <= err_d;
      lost_q      <= lost_d;
      hold_q      <= hold_d;
      rdata_q     <= rdata_d;
    end
  end

  // aec is used directly so a bus steal releases data in the same clock.
  assign data_oe   = (cmd_rw_q == RW_WRITE) && (state_q == ST_CYCLE) && phi2 && aec;
  assign data_6502 = data_oe ? cmd_wdata_q : 8'hzz;

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign rsp_valid    = (state_q == ST_DONE);
  assign rsp_err      = (state_q == ST_DONE) && err_q;
  // Present new read data together with the response pulse, then hold it.
  assign rsp_rdata    = ((state_q == ST_DONE) && !err_q && (cmd_rw_q == RW_READ)) ? hold_q : rdata_q;
  assign r_w_6502     = rw_q;
  assign address_6502 = addr_q;

endmodule

// File: tb/tb_bus_cycle_master.sv
// tb/tb_bus_cycle_master.sv - self-checking bench for bus_cycle_master
module tb_bus_cycle_master;
  import bus_pkg::*;

  localparam int C     = 8;
  localparam int H     = C / 2;
  localparam int RMAX  = 15;
  localparam int AEC_N = 600;

  logic        clock = 1'b0;
  logic        _reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        phi2;
  logic        r_w_6502;
  logic [15:0] address_6502;
  tri1  [7:0]  data_bus;
  logic        aec;
  logic        busy;
  logic [7:0]  bus_val;

  int total = 0;
  int bad   = 0;

  logic aec_tab [AEC_N];

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdv;
    int          mode;
    int          lat;
    int          att;
    logic        err;
  } vec_t;

  vec_t vecs [6];

  always #5 clock = ~clock;

  // Simple bus slave: drives read data whenever the master reads in phi2-high.
  assign data_bus = (phi2 && r_w_6502) ? bus_val : 8'hzz;

  bus_cycle_master #(
    .CYCLE_CLKS(C),
    .RETRY_MAX (RMAX)
  ) dut (
    .clock        (clock),
    ._reset       (_reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .phi2         (phi2),
    .r_w_6502     (r_w_6502),
    .address_6502 (address_6502),
    .data_6502    (data_bus),
    .aec          (aec),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // aec_tab[k] is the aec level seen at the k-th rising edge after accept.
  function automatic void fill_aec(input int mode);
    for (int k = 0; k < AEC_N; k++) begin
      case (mode)
        1:       aec_tab[k] = !(k >= 1 && k <= 20);
        2:       aec_tab[k] = (k != 7);
        3:       aec_tab[k] = (k == 0) || (((k - 1) % (C + 1)) < H + 1);
        4:       aec_tab[k] = (k != 1);
        default: aec_tab[k] = 1'b1;
      endcase
    end
  endfunction

  // Reference: an attempt starts at the first edge with aec high; it is lost if
  // aec is low at any of the phi2-high edges; a lost attempt re-waits for aec.
  function automatic void model(output int lat, output int att, output logic err);
    int k;
    int s;
    logic lost;
    k   = 1;
    att = 0;
    err = 1'b0;
    lat = -1;
    while (k < AEC_N - C - 1) begin
      if (!aec_tab[k]) begin
        k++;
      end else begin
        s = k;
        att++;
        lost = 1'b0;
        for (int j = H + 1; j <= C; j++) begin
          if (!aec_tab[s + j]) lost = 1'b1;
        end
        if (!lost || att == RMAX + 1) begin
          err = lost;
          lat = s + C + 1;
          return;
        end
        k = s + C + 1;
      end
    end
  endfunction

  // Issue one command and watch it to completion; starts and ends at a negedge.
  task automatic run_cmd(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                         input logic [7:0] rv, output int lat, output int att,
                         output logic err, output logic [7:0] rd);
    int   k;
    logic prev_phi2;
    logic [7:0] exp_d;
    lat = -1;
    att = 0;
    err = 1'b0;
    rd  = 8'h00;
    prev_phi2 = 1'b0;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wd;
    bus_val   = rv;
    aec       = aec_tab[0];
    chk("ready_before", {31'b0, cmd_ready}, 32'd1);
    @(posedge clock);
    k = 0;
    while (k < AEC_N - 1) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      if (k == 0) begin
        chk("ready_drop", {31'b0, cmd_ready}, 32'd0);
        chk("busy_set", {31'b0, busy}, 32'd1);
      end
      if (phi2 && !prev_phi2) att++;
      prev_phi2 = phi2;
      if (phi2) begin
        chk("addr", {16'b0, address_6502}, {16'b0, addr});
        chk("r_w", {31'b0, r_w_6502}, {31'b0, rw});
      end
      if (phi2 && rw == RW_WRITE && aec) exp_d = wd;
      else if (phi2 && rw == RW_READ) exp_d = rv;
      else exp_d = 8'hFF;
      chk("data", {24'b0, data_bus}, {24'b0, exp_d});
      if (rsp_valid) begin
        lat = k + 1;
        err = rsp_err;
        rd  = rsp_rdata;
        break;
      end
      aec = aec_tab[k + 1];
      @(posedge clock);
      k++;
    end
    aec = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
    chk("ready_back", {31'b0, cmd_ready}, 32'd1);
    chk("rdata_hold", {24'b0, rsp_rdata}, {24'b0, rd});
  endtask

  initial begin
    int   lat, att, m_lat, m_att, n_rsp;
    logic err, m_err;
    logic [7:0] rd, exp_rdata;
    logic rw;
    logic [15:0] addr;
    logic [7:0] wd, rv;
    int p;

    vecs[0] = '{RW_WRITE, PIO_DATA_ADDR, 8'h5A, 8'h00, 0, 10,  1,  1'b0};
    vecs[1] = '{RW_READ,  16'hFF3E,      8'h00, 8'hC3, 0, 10,  1,  1'b0};
    vecs[2] = '{RW_WRITE, 16'h1234,      8'h81, 8'h00, 1, 30,  1,  1'b0};
    vecs[3] = '{RW_WRITE, 16'hBEEF,      8'h3C, 8'h00, 2, 19,  2,  1'b0};
    vecs[4] = '{RW_READ,  16'h8000,      8'h00, 8'h99, 3, 145, 16, 1'b1};
    vecs[5] = '{RW_READ,  PIO_DDR_ADDR,  8'h00, 8'h6E, 4, 11,  1,  1'b0};

    _reset    = 1'b0;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b1;
    cmd_addr  = 16'h0;
    cmd_wdata = 8'h0;
    aec       = 1'b1;
    bus_val   = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_phi2", {31'b0, phi2}, 32'd0);
    chk("rst_rw", {31'b0, r_w_6502}, 32'd1);
    chk("rst_addr", {16'b0, address_6502}, 32'h0);
    chk("rst_data", {24'b0, data_bus}, 32'hFF);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", {24'b0, rsp_rdata}, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    _reset = 1'b1;
    @(negedge clock);

    exp_rdata = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fill_aec(vecs[i].mode);
      run_cmd(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rdv, lat, att, err, rd);
      if (vecs[i].rw == RW_READ && !vecs[i].err) exp_rdata = vecs[i].rdv;
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_att", i), att, vecs[i].att);
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
      chk($sformatf("vec%0d_rdata", i), {24'b0, rd}, {24'b0, exp_rdata});
    end

    for (int i = 0; i < 24; i++) begin
      rw   = $urandom_range(0, 1) == 1;
      addr = 16'($urandom);
      wd   = 8'($urandom_range(0, 254));
      rv   = 8'($urandom_range(0, 254));
      case ($urandom_range(0, 2))
        0:       p = 0;
        1:       p = 10;
        default: p = 30;
      endcase
      for (int k = 0; k < AEC_N; k++) aec_tab[k] = ($urandom_range(0, 99) >= p);
      model(m_lat, m_att, m_err);
      run_cmd(rw, addr, wd, rv, lat, att, err, rd);
      if (rw == RW_READ && !m_err) exp_rdata = rv;
      chk($sformatf("rnd%0d_lat", i), lat, m_lat);
      chk($sformatf("rnd%0d_att", i), att, m_att);
      chk($sformatf("rnd%0d_err", i), {31'b0, err}, {31'b0, m_err});
      chk($sformatf("rnd%0d_rdata", i), {24'b0, rd}, {24'b0, exp_rdata});
    end

    // Reset in the middle of a write cycle, at phase count 5.
    cmd_valid = 1'b1;
    cmd_rw    = RW_WRITE;
    cmd_addr  = 16'h4321;
    cmd_wdata = 8'hA5;
    aec       = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("mid_data", {24'b0, data_bus}, 32'hA5);
    chk("mid_rw", {31'b0, r_w_6502}, 32'd0);
    _reset = 1'b0;
    #1;
    chk("rstmid_data", {24'b0, data_bus}, 32'hFF);
    chk("rstmid_rw", {31'b0, r_w_6502}, 32'd1);
    chk("rstmid_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rstmid_phi2", {31'b0, phi2}, 32'd0);
    chk("rstmid_rdata", {24'b0, rsp_rdata}, 32'h0);
    @(negedge clock);
    _reset = 1'b1;
    n_rsp = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (rsp_valid) n_rsp++;
    end
    chk("rstmid_no_rsp", n_rsp, 0);
    chk("rstmid_idle", {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
